// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the 4x4 matrix keypad scanner.
//   state_t   - scanner FSM state encoding
//   KEY_STAR  - code emitted for the '*' key
//   KEY_HASH  - code emitted for the '#' key
//   low_row() - index of the lowest-numbered active (low) row in a row pattern
//   key_map() - row/column position to 4-bit key code
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    // Lowest row index wins when several rows are pulled low in one column.
    function automatic logic [1:0] low_row(input logic [3:0] rows);
        logic [1:0] idx;
        if (!rows[0])      idx = 2'd0;
        else if (!rows[1]) idx = 2'd1;
        else if (!rows[2]) idx = 2'd2;
        else               idx = 2'd3;
        return idx;
    endfunction

    // Keypad layout:  r0: 1 2 3 A   r1: 4 5 6 B   r2: 7 8 9 C   r3: * 0 # D
    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'h0:    code = 4'h1;
            4'h1:    code = 4'h2;
            4'h2:    code = 4'h3;
            4'h3:    code = 4'hA;
            4'h4:    code = 4'h4;
            4'h5:    code = 4'h5;
            4'h6:    code = 4'h6;
            4'h7:    code = 4'hB;
            4'h8:    code = 4'h7;
            4'h9:    code = 4'h8;
            4'hA:    code = 4'h9;
            4'hB:    code = 4'hC;
            4'hC:    code = KEY_STAR;
            4'hD:    code = 4'h0;
            4'hE:    code = KEY_HASH;
            4'hF:    code = 4'hD;
            // NOTE: a default on every case keeps combinational logic fully
            // specified; a missing branch in always_comb would infer a latch.
            default: code = 4'h0;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_scanner_tick.sv
// scan_tick: free-running divider producing the keypad scan tick.
//   clk   - system clock
//   reset - synchronous, active-high reset (counter returns to 0)
//   tick  - high for one clk cycle when the counter is at CLK_DIV-1
module scan_tick #(
    parameter int CLK_DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int               CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge value of its inputs regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset)            cnt <= '0;
        else if (cnt == LAST) cnt <= '0;
        else                  cnt <= cnt + CNT_W'(1);
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad one column at a time,
// debounces press and release, and reports the accepted key.
//   clk       - system clock
//   reset     - synchronous, active-high reset
//   row_in    - keypad rows, active-low, asynchronous to clk
//   col_out   - column drive, exactly one bit low
//   key_code  - code of the last accepted key, held until the next accept
//   key_valid - one-cycle strobe when a new key is accepted
//   key_held  - high from accept until the release has been debounced
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int CLK_DIV        = 50000,
    parameter int DEBOUNCE_TICKS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int               DEB_W    = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_TICKS - 1);

    logic tick;

    scan_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_scan_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // Two-flop synchronizer on the asynchronous row inputs.
    logic [3:0] rows_meta;
    logic [3:0] rows_s;

    // NOTE: the synchronizer resets to the idle (all-high) pattern so the FSM
    // never sees a phantom press in the first cycles after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rows_meta <= 4'hF;
            rows_s    <= 4'hF;
        end else begin
            rows_meta <= row_in;
            rows_s    <= rows_meta;
        end
    end

    logic rows_idle;
    assign rows_idle = (rows_s == 4'hF);

    state_t           state;
    logic [1:0]       col_idx;
    logic [3:0]       row_lat;
    logic [DEB_W-1:0] deb_cnt;

    // Column only moves on a tick, so rows are always sampled a full tick
    // after the drive changed, which covers the keypad settle time.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SCAN;
            col_idx   <= 2'd0;
            col_out   <= 4'b1110;
            row_lat   <= 4'hF;
            deb_cnt   <= '0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (tick) begin
                case (state)
                    SCAN: begin
                        if (rows_idle) begin
                            col_idx <= col_idx + 2'd1;
                            col_out <= {col_out[2:0], col_out[3]};
                        end else begin
                            row_lat <= rows_s;
                            deb_cnt <= '0;
                            state   <= DEBOUNCE;
                        end
                    end

                    DEBOUNCE: begin
                        if (rows_s != row_lat) begin
                            state <= SCAN;
                        end else begin
                            deb_cnt <= deb_cnt + DEB_W'(1);
                            // This match is the DEBOUNCE_TICKS-th in a row.
                            if (deb_cnt == DEB_LAST) begin
                                key_code  <= key_map(low_row(row_lat), col_idx);
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                state     <= PRESSED;
                            end
                        end
                    end

                    PRESSED: begin
                        if (rows_idle) begin
                            deb_cnt <= '0;
                            state   <= RELEASE;
                        end
                    end

                    RELEASE: begin
                        if (!rows_idle) begin
                            // Release bounce: the key is still the same press.
                            state <= PRESSED;
                        end else begin
                            deb_cnt <= deb_cnt + DEB_W'(1);
                            if (deb_cnt == DEB_LAST) begin
                                key_held <= 1'b0;
                                state    <= SCAN;
                                col_idx  <= col_idx + 2'd1;
                                col_out  <= {col_out[2:0], col_out[3]};
                            end
                        end
                    end

                    default: state <= SCAN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed self-checking bench for keypad_scanner with
// CLK_DIV=4 and DEBOUNCE_TICKS=3. A behavioural keypad drives row_in from the
// set of pressed keys and the DUT's column drive.
module tb_keypad_scanner;

    logic       clk;
    logic       reset;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    // Pressed keys, bit index = row*4 + col.
    logic [15:0] keys;

    int n_checks;
    int n_errors;
    int valid_cnt;

    keypad_scanner #(
        .CLK_DIV        (4),
        .DEBOUNCE_TICKS (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Matrix model: a pressed key pulls its row low while its column is driven.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4 + c] && !col_out[c]) row_in[r] = 1'b0;
    end

    // Count strobes; sampled on posedge so the count is settled at negedge.
    always @(posedge clk) begin
        if (key_valid) valid_cnt <= valid_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_col(input logic [3:0] target, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (col_out == target) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_col_reached"}, 32'(seen), 32'd1);
    endtask

    task automatic wait_valid(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (key_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_valid_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic wait_release(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!key_held) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_released"}, 32'(seen), 32'd1);
    endtask

    task automatic press_key(input logic [15:0] mask, input logic [3:0] exp, input string tag);
        int base;
        base = valid_cnt;
        keys = mask;
        wait_valid(tag);
        check({tag, "_code"}, 32'(key_code), 32'(exp));
        check({tag, "_held"}, 32'(key_held), 32'd1);
        cycles(1);
        check({tag, "_pulse_len"}, 32'(key_valid), 32'd0);
        keys = '0;
        wait_release(tag);
        check({tag, "_code_kept"}, 32'(key_code), 32'(exp));
        check({tag, "_pulses"}, 32'(valid_cnt - base), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        n_checks  = 0;
        n_errors  = 0;
        valid_cnt = 0;
        keys      = '0;
        reset     = 1'b1;

        // Reset state and free-running column rotation.
        cycles(2);
        check("rst_col", 32'(col_out), 32'h0000_000E);
        check("rst_valid", 32'(key_valid), 32'd0);
        check("rst_held", 32'(key_held), 32'd0);
        check("rst_code", 32'(key_code), 32'd0);
        reset = 1'b0;
        cycles(3);
        check("rot_hold", 32'(col_out), 32'h0000_000E);
        cycles(1);
        check("rot_c1", 32'(col_out), 32'h0000_000D);
        cycles(4);
        check("rot_c2", 32'(col_out), 32'h0000_000B);
        cycles(4);
        check("rot_c3", 32'(col_out), 32'h0000_0007);
        cycles(4);
        check("rot_c0", 32'(col_out), 32'h0000_000E);

        // Clean press of '6' (row1/col2) with exact accept and release timing.
        base = valid_cnt;
        keys = 16'h0040;
        wait_col(4'b1011, "k6");
        cycles(15);
        check("k6_early", 32'(key_valid), 32'd0);
        cycles(1);
        check("k6_valid", 32'(key_valid), 32'd1);
        check("k6_code", 32'(key_code), 32'h6);
        check("k6_held", 32'(key_held), 32'd1);
        cycles(24);
        check("k6_pulses", 32'(valid_cnt - base), 32'd1);
        check("k6_frozen", 32'(col_out), 32'h0000_000B);
        keys = '0;
        cycles(15);
        check("k6_hold_tail", 32'(key_held), 32'd1);
        cycles(1);
        check("k6_release", 32'(key_held), 32'd0);
        check("k6_next_col", 32'(col_out), 32'h0000_0007);

        // Press bounce on col1: row0 low for one tick only, then a real press of '2'.
        wait_col(4'b1101, "b2");
        base = valid_cnt;
        keys = 16'h0002;
        cycles(4);
        keys = '0;
        cycles(4);
        check("b2_col_kept", 32'(col_out), 32'h0000_000D);
        check("b2_no_valid", 32'(valid_cnt - base), 32'd0);
        keys = 16'h0002;
        cycles(15);
        check("b2_early", 32'(key_valid), 32'd0);
        cycles(1);
        check("b2_valid", 32'(key_valid), 32'd1);
        check("b2_code", 32'(key_code), 32'h2);
        cycles(1);
        keys = '0;
        wait_release("b2");
        check("b2_pulses", 32'(valid_cnt - base), 32'd1);

        // Priority and special codes.
        press_key(16'h1010, 4'h4, "multi_row");
        press_key(16'h1000, 4'hE, "star");
        press_key(16'h4000, 4'hF, "hash");

        // Release bounce on 'D' (row3/col3).
        base = valid_cnt;
        keys = 16'h8000;
        wait_valid("rb");
        check("rb_code", 32'(key_code), 32'hD);
        cycles(4);
        keys = '0;
        cycles(12);
        keys = 16'h8000;
        cycles(4);
        check("rb_held", 32'(key_held), 32'd1);
        check("rb_col", 32'(col_out), 32'h0000_0007);
        cycles(20);
        check("rb_held_late", 32'(key_held), 32'd1);
        check("rb_pulses", 32'(valid_cnt - base), 32'd1);
        keys = '0;
        wait_release("rb");

        // Reset while '5' is held, then re-detection of the same press.
        keys = 16'h0020;
        wait_valid("rst5");
        check("rst5_code", 32'(key_code), 32'h5);
        cycles(2);
        reset = 1'b1;
        cycles(1);
        check("rst5_held", 32'(key_held), 32'd0);
        check("rst5_col", 32'(col_out), 32'h0000_000E);
        check("rst5_code_clr", 32'(key_code), 32'd0);
        reset = 1'b0;
        base = valid_cnt;
        wait_valid("rst5_again");
        check("rst5_again_code", 32'(key_code), 32'h5);
        cycles(40);
        check("rst5_pulses", 32'(valid_cnt - base), 32'd1);
        keys = '0;
        wait_release("rst5");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
